// File: rtl/gait_pkg.sv
// Shared codes for the line-following walker.
// State, steering and leg position enums.
package gait_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH_A = 2'd1,
    PH_B = 2'd2,
    HALT = 2'd3
  } state_e;

  // Encoded as {l, r} so the sensor pair reads directly.
  typedef enum logic [1:0] {
    FWD    = 2'b00,
    TURN_R = 2'b01,
    TURN_L = 2'b10,
    STOP   = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    POS_LO  = 2'd0,
    POS_MID = 2'd1,
    POS_HI  = 2'd2
  } pos_e;

  function automatic dir_e decode_dir(
    input logic l,
    input logic r
  );
    dir_e d;
    unique case (1'b1)
      (l && r):  d = STOP;
      (l && !r): d = TURN_L;
      (!l && r): d = TURN_R;
      default:   d = FWD;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gait_line_follower_servo_pwm.sv
// One servo channel on a shared frame counter.
// Width is latched at frame start so pulses never truncate.
module servo_pwm #(
  parameter int W         = 18,
  parameter int RST_WIDTH = 18_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] frame_cnt,
  input  logic [W-1:0] width,
  output logic         pulse
);

  logic [W-1:0] width_q, width_d;
  logic         pulse_q, pulse_d;

  // Take a new width only at count 0 and compare against it.
  always_comb begin
    width_d = width_q;
    pulse_d = frame_cnt < width_q;
    if (frame_cnt == '0) begin
      width_d = width;
      pulse_d = width != '0;
    end
  end

  // Width and pulse registers; pulse drops at once on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q <= W'(RST_WIDTH);
      pulse_q <= 1'b0;
    end else begin
      width_q <= width_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/gait_line_follower.sv
// Walker top: IR sync/debounce, step tick,
// gait FSM, step counter and three servo channels.
module gait_line_follower
  import gait_pkg::*;
#(
  parameter int CLK_DIV      = 1_600_000,
  parameter int DEB_LEN      = 16,
  parameter int SERVO_PERIOD = 240_000,
  parameter int PULSE_LO     = 12_000,
  parameter int PULSE_MID    = 18_000,
  parameter int PULSE_HI     = 24_000,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             r_ir,
  input  logic             l_ir,
  output logic             r_leg,
  output logic             l_leg,
  output logic             c_leg,
  output logic [CNT_W-1:0] step_cnt,
  output logic [1:0]       state
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DEB_LEN + 1);
  localparam int FW = $clog2(SERVO_PERIOD + 1);

  logic r_s1_q, r_s2_q, l_s1_q, l_s2_q;

  // Two-flop synchronisers for the raw sensor lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_q <= 1'b0;
      r_s2_q <= 1'b0;
      l_s1_q <= 1'b0;
      l_s2_q <= 1'b0;
    end else begin
      r_s1_q <= r_ir;
      r_s2_q <= r_s1_q;
      l_s1_q <= l_ir;
      l_s2_q <= l_s1_q;
    end
  end

  logic [DW-1:0] r_cnt_q, r_cnt_d, l_cnt_q, l_cnt_d;
  logic          r_deb_q, r_deb_d, l_deb_q, l_deb_d;

  // Right debounce: accept after DEB_LEN differing cycles.
  always_comb begin
    r_cnt_d = '0;
    r_deb_d = r_deb_q;
    if (r_s2_q != r_deb_q) begin
      if (r_cnt_q == DW'(DEB_LEN - 1)) r_deb_d = r_s2_q;
      else r_cnt_d = r_cnt_q + DW'(1);
    end
  end

  // Left debounce: same rule as the right channel.
  always_comb begin
    l_cnt_d = '0;
    l_deb_d = l_deb_q;
    if (l_s2_q != l_deb_q) begin
      if (l_cnt_q == DW'(DEB_LEN - 1)) l_deb_d = l_s2_q;
      else l_cnt_d = l_cnt_q + DW'(1);
    end
  end

  // Debounce registers for both channels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_q <= '0;
      r_deb_q <= 1'b0;
      l_cnt_q <= '0;
      l_deb_q <= 1'b0;
    end else begin
      r_cnt_q <= r_cnt_d;
      r_deb_q <= r_deb_d;
      l_cnt_q <= l_cnt_d;
      l_deb_q <= l_deb_d;
    end
  end

  logic [TW-1:0] tick_q, tick_d;
  logic          tick;

  // Step divider; frozen while walking is disabled.
  always_comb begin
    tick   = en && (tick_q == TW'(CLK_DIV - 1));
    tick_d = tick_q;
    if (en) tick_d = tick ? '0 : tick_q + TW'(1);
  end

  dir_e             dir_now, dir_q, dir_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             stop;

  assign dir_now = decode_dir(l_deb_q, r_deb_q);
  assign stop    = dir_now == STOP;

  // Gait state, steering and step registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q  <= '0;
      state_q <= IDLE;
      dir_q   <= FWD;
      step_q  <= '0;
    end else begin
      tick_q  <= tick_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

  // Next gait state; disable wins over a coincident tick.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dir_d   = tick ? dir_now : dir_q;
    if (!en) begin
      state_d = IDLE;
    end else if (tick) begin
      unique case (state_q)
        IDLE: state_d = PH_A;
        PH_A, PH_B: begin
          if (stop) begin
            state_d = HALT;
          end else begin
            state_d = (state_q == PH_A) ? PH_B : PH_A;
            step_d  = step_q + CNT_W'(1);
          end
        end
        HALT: if (!stop) state_d = PH_A;
        default: state_d = IDLE;
      endcase
    end
  end

  pos_e c_pos, r_pos, l_pos, swing;

  // Leg positions from gait phase and last sampled steering.
  always_comb begin
    c_pos = POS_MID;
    r_pos = POS_MID;
    l_pos = POS_MID;
    swing = POS_MID;
    unique case (state_q)
      PH_A: begin
        c_pos = POS_HI;
        swing = POS_LO;
      end
      PH_B: begin
        c_pos = POS_LO;
        swing = POS_HI;
      end
      default: ;
    endcase
    if (dir_q == FWD || dir_q == TURN_L) r_pos = swing;
    if (dir_q == FWD || dir_q == TURN_R) l_pos = swing;
  end

  function automatic logic [FW-1:0] pos_width(input pos_e p);
    logic [FW-1:0] w;
    unique case (p)
      POS_LO:  w = FW'(PULSE_LO);
      POS_HI:  w = FW'(PULSE_HI);
      default: w = FW'(PULSE_MID);
    endcase
    return w;
  endfunction

  logic [FW-1:0] frame_q, frame_d;

  // Free-running servo frame counter.
  always_comb begin
    frame_d = (frame_q == FW'(SERVO_PERIOD - 1)) ? '0 : frame_q + FW'(1);
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_q <= '0;
    else frame_q <= frame_d;
  end

  servo_pwm #(.W(FW), .RST_WIDTH(PULSE_MID)) u_c_pwm (
    .clk(clk), .rst(rst), .frame_cnt(frame_q),
    .width(pos_width(c_pos)), .pulse(c_leg)
  );

  servo_pwm #(.W(FW), .RST_WIDTH(PULSE_MID)) u_r_pwm (
    .clk(clk), .rst(rst), .frame_cnt(frame_q),
    .width(pos_width(r_pos)), .pulse(r_leg)
  );

  servo_pwm #(.W(FW), .RST_WIDTH(PULSE_MID)) u_l_pwm (
    .clk(clk), .rst(rst), .frame_cnt(frame_q),
    .width(pos_width(l_pos)), .pulse(l_leg)
  );

  assign step_cnt = step_q;
  assign state    = state_q;

endmodule

// File: tb/tb_gait_line_follower.sv
// Scoreboard bench for gait_line_follower with a
// behavioural walker model and randomized sensor input.
module tb_gait_line_follower;

  localparam int CLK_DIV = 10;
  localparam int DEB_LEN = 4;
  localparam int PERIOD  = 100;
  localparam int W_LO    = 5;
  localparam int W_MID   = 10;
  localparam int W_HI    = 15;
  localparam int CNT_W   = 4;

  localparam int D_FWD = 0;
  localparam int D_TR  = 1;
  localparam int D_TL  = 2;
  localparam int D_STP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic r_ir = 1'b0;
  logic l_ir = 1'b0;
  logic r_leg, l_leg, c_leg;
  logic [CNT_W-1:0] step_cnt;
  logic [1:0] state;

  always #5 clk = ~clk;

  gait_line_follower #(
    .CLK_DIV(CLK_DIV), .DEB_LEN(DEB_LEN), .SERVO_PERIOD(PERIOD),
    .PULSE_LO(W_LO), .PULSE_MID(W_MID), .PULSE_HI(W_HI),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .r_ir(r_ir), .l_ir(l_ir),
    .r_leg(r_leg), .l_leg(l_leg), .c_leg(c_leg),
    .step_cnt(step_cnt), .state(state)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Scoreboard queues: per-leg pulse widths and per-cycle state/step.
  int wq_c[$];
  int wq_r[$];
  int wq_l[$];
  int sq_st[$];
  int sq_sc[$];

  // Reference model state (leg index 0=c, 1=r, 2=l; ch 0=l, 1=r).
  int m_hist[2][$];
  int m_deb[2];
  int m_run[2];
  int m_enabled_cycles;
  int m_state, m_dir, m_step, m_frame;

  function automatic int exp_width(input int leg, input int st, input int dir);
    int swing;
    if (st == 0 || st == 3) return W_MID;
    if (leg == 0) return (st == 1) ? W_HI : W_LO;
    swing = (st == 1) ? W_LO : W_HI;
    if (leg == 1) return (dir == D_FWD || dir == D_TL) ? swing : W_MID;
    return (dir == D_FWD || dir == D_TR) ? swing : W_MID;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_hist[c].delete();
      m_hist[c].push_back(0);
      m_hist[c].push_back(0);
      m_deb[c] = 0;
      m_run[c] = 0;
    end
    m_enabled_cycles = 0;
    m_state = 0;
    m_dir = D_FWD;
    m_step = 0;
    m_frame = 0;
  endtask

  task automatic model_edge();
    bit tick;
    int dnow, synced;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_frame == 0) begin
      wq_c.push_back(exp_width(0, m_state, m_dir));
      wq_r.push_back(exp_width(1, m_state, m_dir));
      wq_l.push_back(exp_width(2, m_state, m_dir));
    end
    tick = en && ((m_enabled_cycles % CLK_DIV) == CLK_DIV - 1);
    dnow = 2 * m_deb[0] + m_deb[1];
    if (!en) begin
      m_state = 0;
    end else if (tick) begin
      if (m_state == 0) m_state = 1;
      else if (m_state == 3) m_state = (dnow == D_STP) ? 3 : 1;
      else if (dnow == D_STP) m_state = 3;
      else begin
        m_state = 3 - m_state;
        m_step = (m_step + 1) % (1 << CNT_W);
      end
      m_dir = dnow;
    end
    if (en) m_enabled_cycles++;
    for (int c = 0; c < 2; c++) begin
      synced = m_hist[c].pop_front();
      if (synced != m_deb[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB_LEN) begin
          m_deb[c] = synced;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_hist[c].push_back((c == 0) ? int'(l_ir) : int'(r_ir));
    end
    m_frame = (m_frame + 1) % PERIOD;
    sq_st.push_back(m_state);
    sq_sc.push_back(m_step);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Monitor: per-cycle state/step, per-pulse width on falling edge.
  int hi[3];
  bit prev[3];

  function automatic bit leg_val(input int leg);
    case (leg)
      0: return c_leg;
      1: return r_leg;
      default: return l_leg;
    endcase
  endfunction

  task automatic pop_w(input int leg, output int w, output bit ok);
    ok = 1'b1;
    w = 0;
    case (leg)
      0: if (wq_c.size() > 0) w = wq_c.pop_front(); else ok = 1'b0;
      1: if (wq_r.size() > 0) w = wq_r.pop_front(); else ok = 1'b0;
      default: if (wq_l.size() > 0) w = wq_l.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic monitor_edge();
    int w;
    bit ok;
    bit cur;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        hi[i] = 0;
        prev[i] = 1'b0;
      end
      return;
    end
    if (sq_st.size() == 0) begin
      check("state_queue_empty", 0, 1);
    end else begin
      check("state", int'(state), sq_st.pop_front());
      check("step_cnt", int'(step_cnt), sq_sc.pop_front());
    end
    for (int i = 0; i < 3; i++) begin
      cur = leg_val(i);
      if (cur) begin
        hi[i]++;
      end else if (prev[i]) begin
        pop_w(i, w, ok);
        if (!ok) check($sformatf("width_leg%0d_unexpected", i), hi[i], -1);
        else check($sformatf("width_leg%0d", i), hi[i], w);
        hi[i] = 0;
      end
      prev[i] = cur;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitor_edge();
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  int saved_step;
  int guard;

  initial begin
    #2 rst = 1'b0;
    cycles(4);
    check("rst_state", int'(state), 0);
    check("rst_step", int'(step_cnt), 0);
    check("rst_legs", int'({c_leg, r_leg, l_leg}), 0);
    rst = 1'b1;

    // Idle frames with walking disabled: all legs mid width.
    cycles(310);

    // Forward walk long enough to wrap the step counter.
    en = 1'b1;
    cycles(420);

    // Left line seen; short glitch on the right sensor.
    l_ir = 1'b1;
    cycles(150);
    r_ir = 1'b1;
    cycles(3);
    r_ir = 1'b0;
    cycles(150);

    // Crossing: halt, then resume.
    r_ir = 1'b1;
    cycles(250);
    l_ir = 1'b0;
    r_ir = 1'b0;
    cycles(200);

    // Drop enable on the very cycle a tick would fire.
    guard = 0;
    while (!((m_enabled_cycles % CLK_DIV) == CLK_DIV - 1) && guard < 40) begin
      cycles(1);
      guard++;
    end
    check("tick_align_timeout", int'(guard < 40), 1);
    check("walking_before_drop", int'(state != 2'd0), 1);
    saved_step = m_step;
    en = 1'b0;
    cycles(1);
    check("en_drop_state", int'(state), 0);
    check("en_drop_step", int'(step_cnt), saved_step);
    cycles(60);

    // Randomised sensors and enable, including sub-debounce glitches.
    for (int s = 0; s < 150; s++) begin
      en = ($urandom_range(0, 7) != 0);
      l_ir = $urandom_range(0, 1);
      r_ir = $urandom_range(0, 1);
      cycles(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 30));
    end
    en = 1'b1;
    l_ir = 1'b0;
    r_ir = 1'b0;
    cycles(150);

    // Reset in the middle of a pulse.
    guard = 0;
    while (m_frame != 4 && guard < 2 * PERIOD) begin
      cycles(1);
      guard++;
    end
    check("frame_align_timeout", int'(guard < 2 * PERIOD), 1);
    check("mid_pulse_legs_high", int'({c_leg, r_leg, l_leg}), 7);
    rst = 1'b0;
    #1;
    check("async_rst_legs", int'({c_leg, r_leg, l_leg}), 0);
    check("async_rst_state", int'(state), 0);
    check("async_rst_step", int'(step_cnt), 0);
    wq_c.delete();
    wq_r.delete();
    wq_l.delete();
    cycles(3);
    rst = 1'b1;
    en = 1'b0;
    cycles(250);

    check("leftover_c", int'(wq_c.size() <= 1), 1);
    check("leftover_r", int'(wq_r.size() <= 1), 1);
    check("leftover_l", int'(wq_l.size() <= 1), 1);
    check("leftover_state", sq_st.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gait_line_follower.md
Name: gait_line_follower

Overview:
Parametrised successor to the doodle pump/counter top-level. It closes the loop between the two IR line sensors and the three leg servos. IR inputs are synchronised and debounced. A step tick (clock-enable divider) drives a walking-gait FSM that steers by sensor state. Each leg gets a glitch-free servo pulse, and a step counter feeds the LED bank.

Parameters:
CLK_DIV, 1_600_000, clk cycles per gait step tick (>=2)
DEB_LEN, 16, consecutive stable cycles before a debounced IR value changes (>=1)
SERVO_PERIOD, 240_000, servo frame length in clk cycles (20 ms at 12 MHz)
PULSE_LO, 12_000, pulse width for leg position LO (1 ms)
PULSE_MID, 18_000, pulse width for leg position MID (1.5 ms)
PULSE_HI, 24_000, pulse width for leg position HI (2 ms)
CNT_W, 8, step counter width

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
en  in  1  walk enable (switch, level)
r_ir  in  1  right IR sensor; 1 = line (dark) seen; asynchronous
l_ir  in  1  left IR sensor; same as r_ir
r_leg  out  1  right leg servo pulse
l_leg  out  1  left leg servo pulse
c_leg  out  1  centre (tilt) leg servo pulse
step_cnt  out  CNT_W  completed half-steps, to LEDs
state  out  2  gait state code, debug

Behaviour:
- Reset (rst=0, async): r_leg/l_leg/c_leg=0, step_cnt=0, state=IDLE, tick counter=0, frame counter=0, debounced IR=0, latched widths=PULSE_MID.
- IR path: 2-FF synchroniser, then debounce. The debounced value takes the synchronised value once it has differed from the current debounced value for DEB_LEN consecutive cycles. Any bounce restarts the count.
- Tick: counter 0..CLK_DIV-1 advances only while en=1 and holds while en=0. tick=1 for one cycle when count==CLK_DIV-1, then wraps to 0.
- Direction decode (combinational from debounced l,r), sampled only on tick:
  - 00 -> FWD
  - 10 -> TURN_L
  - 01 -> TURN_R
  - 11 -> STOP (crossing or lost)
- Gait FSM, states IDLE=0, PH_A=1, PH_B=2, HALT=3; transitions on tick unless noted:
  - IDLE -> PH_A on tick.
  - PH_A <-> PH_B while dir!=STOP.
  - PH_A/PH_B -> HALT when dir==STOP.
  - HALT -> PH_A when dir!=STOP.
  - en=0 -> IDLE on the next clk edge from any state, with priority over a same-cycle tick.
- Leg positions:
  - IDLE/HALT: all MID.
  - c_leg: PH_A=HI, PH_B=LO.
  - r_leg/l_leg, FWD: both follow the c_leg pattern inverted (PH_A=LO, PH_B=HI).
  - TURN_L: r_leg swings as in FWD, l_leg=MID.
  - TURN_R: l_leg swings, r_leg=MID.
  - The dir used for legs is the value registered at the last tick.
- step_cnt: +1 on every PH_A<->PH_B transition, wraps from 2^CNT_W-1 to 0. Not incremented on entry to or exit from HALT/IDLE. Held when en=0; cleared only by reset.
- Servo PWM: frame counter 0..SERVO_PERIOD-1 runs freely from reset, independent of en.
  - Each leg latches its target width only when frame counter==0, so the pulse never truncates mid-frame.
  - Output=1 while frame counter < latched width. Output is registered, so one clk latency from the counter.
- Reset mid-pulse: outputs drop to 0 immediately. After release, the first frame starts at counter 0 with MID width.

Decomposition:
- Package gait_pkg: state codes (IDLE/PH_A/PH_B/HALT), dir codes (FWD/TURN_L/TURN_R/STOP), position codes (LO/MID/HI).
- Sub-module servo_pwm, instantiated three times with shared frame count: inputs clk, rst, frame_cnt, width; output pulse.
- IR debounce is written inline as two identical processes.

Test Plan (CLK_DIV=10, DEB_LEN=4, SERVO_PERIOD=100, PULSE_LO/MID/HI=5/10/15, CNT_W=4):
1. Reset release, en=0: each leg is high for exactly 10 of every 100 cycles; step_cnt=0; state=0.
2. en=1, l_ir=r_ir=0: state goes IDLE->1->2->1 on ticks every 10 cycles. step_cnt counts 0,1,2… and wraps 15->0. c_leg alternates width 15/5; r_leg/l_leg alternate 5/15.
3. l_ir=1 held: after sync+DEB_LEN (6 cycles) and the next tick, l_leg=MID (10) while r_leg keeps swinging. A 3-cycle glitch on r_ir produces no change.
4. l_ir=r_ir=1: state=3 at the next tick, all widths 10, step_cnt frozen. Clearing the inputs returns state to 1 at the following tick.
5. Width changes mid-frame (frame count 50): the current pulse is unaffected and the new width applies from count 0.
6. en falls on the same cycle as tick: state=0 the next cycle, step_cnt unchanged. Asserting rst low mid-pulse drives all legs to 0 within the same cycle.
